// File: rtl/mont_redc.sv
// Word-serial Montgomery reduction: R = P * 2^-(WORD_W*N_WORDS) mod N.
// Define MONT_REDC_CHECK_EN to add the err output (even N / oversized P).
module mont_redc #(
    parameter int WORD_W  = 64,
    parameter int N_WORDS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [2*WORD_W*N_WORDS-1:0]   P,
    input  logic [WORD_W*N_WORDS-1:0]     N,
    input  logic [WORD_W-1:0]             n_prime,
    output logic [WORD_W*N_WORDS-1:0]     R,
    output logic                          busy,
    output logic                          done
`ifdef MONT_REDC_CHECK_EN
    ,
    output logic                          err
`endif
);

    localparam int MW = WORD_W * N_WORDS;
    localparam int PW = 2 * MW;
    localparam int TW = PW + 1;
    localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC_M,
        ACC,
        FINAL
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0]        t_q;
    logic [MW-1:0]        n_q;
    logic [WORD_W-1:0]    np_q;
    logic [WORD_W-1:0]    m_q;
    logic [IW-1:0]        i_q;

    logic [WORD_W-1:0]    word;
    logic [WORD_W-1:0]    m_d;
    logic [MW+WORD_W-1:0] mn;
    logic [TW-1:0]        addend;
    logic [TW-1:0]        t_acc;
    logic [MW:0]          u;
    logic                 u_ge;
    logic [MW-1:0]        r_fin;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = CALC_M;
            CALC_M: state_d = ACC;
            ACC:    state_d = (i_q == LAST) ? FINAL : CALC_M;
            FINAL:  state_d = IDLE;
        endcase
    end

    // m zeroes the current low word of T once m*N is added at that offset
    always_comb begin
        word   = t_q[i_q*WORD_W +: WORD_W];
        m_d    = word * np_q;
        mn     = {{MW{1'b0}}, m_q} * {{WORD_W{1'b0}}, n_q};
        addend = {{(TW-MW-WORD_W){1'b0}}, mn} << (i_q * WORD_W);
        t_acc  = t_q + addend;
        u      = t_q[TW-1:MW];
        u_ge   = (u >= {1'b0, n_q});
        r_fin  = u_ge ? MW'(u - {1'b0, n_q}) : u[MW-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            t_q  <= '0;
            n_q  <= '0;
            np_q <= '0;
            m_q  <= '0;
            i_q  <= '0;
            R    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        t_q  <= {1'b0, P};
                        n_q  <= N;
                        np_q <= n_prime;
                        i_q  <= '0;
                        busy <= 1'b1;
                    end
                end
                CALC_M: begin
                    m_q <= m_d;
                end
                ACC: begin
                    t_q <= t_acc;
                    if (i_q != LAST) i_q <= i_q + 1'b1;
                end
                FINAL: begin
                    R    <= r_fin;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef MONT_REDC_CHECK_EN
    // Judged on the inputs at acceptance, since T is overwritten afterwards
    logic bad_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            bad_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                bad_q <= ~N[0] | (P[PW-1:MW] >= N);
            end
            if (state_q == FINAL) begin
                err <= bad_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mont_redc.sv
// Scoreboard bench for mont_redc against a divide-by-two reference model.
// Defining MONT_REDC_CHECK_EN also exercises the err output.
module tb_mont_redc;

    localparam int MW = 256;
    localparam int PW = 512;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] P = '0;
    logic [MW-1:0] N = '0;
    logic [63:0]   n_prime = '0;
    logic [MW-1:0] R;
    logic          busy;
    logic          done;
`ifdef MONT_REDC_CHECK_EN
    logic          err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_run = 0;

    typedef struct {
        logic [MW-1:0] r;
        bit            chk_r;
        bit            err_exp;
        int            acc;
    } exp_t;

    exp_t sbq[$];

    mont_redc dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .P(P),
        .N(N),
        .n_prime(n_prime),
        .R(R),
        .busy(busy),
        .done(done)
`ifdef MONT_REDC_CHECK_EN
        ,
        .err(err)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // P * 2^-256 mod n: halve 256 times modulo odd n
    function automatic logic [MW-1:0] model(input logic [PW-1:0] p,
                                            input logic [MW-1:0] n);
        logic [PW-1:0] x;
        logic [PW-1:0] nn;
        nn = {{(PW-MW){1'b0}}, n};
        x  = p % nn;
        for (int k = 0; k < MW; k++) begin
            if (x[0]) x = x + nn;
            x = x >> 1;
        end
        return x[MW-1:0];
    endfunction

    function automatic logic [63:0] np_of(input logic [MW-1:0] n);
        logic [63:0] n0;
        logic [63:0] inv;
        n0  = n[63:0];
        inv = n0;
        repeat (6) inv = inv * (64'd2 - n0 * inv);
        return -inv;
    endfunction

    function automatic logic [MW-1:0] rnd256();
        logic [MW-1:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[MW-33:0], 32'($urandom)};
        return r;
    endfunction

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (cyc - e.acc != 9) begin
                    errors++;
                    $display("FAIL latency got %0d expected 9", cyc - e.acc);
                end
                checks++;
                if (busy_run != 9) begin
                    errors++;
                    $display("FAIL busy_len got %0d expected 9", busy_run);
                end
                if (e.chk_r) begin
                    checks++;
                    if (R !== e.r) begin
                        errors++;
                        $display("FAIL R got %h expected %h", R, e.r);
                    end
                end
`ifdef MONT_REDC_CHECK_EN
                checks++;
                if (err !== e.err_exp) begin
                    errors++;
                    $display("FAIL err got %b expected %b", err, e.err_exp);
                end
`endif
            end
        end
        busy_run = busy ? busy_run + 1 : 0;
    end

    task automatic wait_drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 40) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending %0d expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic issue(input logic [PW-1:0] p, input logic [MW-1:0] n,
                         input logic [63:0] np, input logic [MW-1:0] r,
                         input bit chk_r, input bit err_exp);
        exp_t e;
        P       = p;
        N       = n;
        n_prime = np;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start   = 1'b0;
        P       = '1;
        e       = '{r, chk_r, err_exp, cyc};
        sbq.push_back(e);
        wait_drain();
    endtask

    task automatic run_stream(input int n, input logic [MW-1:0] nmod,
                              input logic [63:0] np);
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [PW-1:0] p;
        exp_t          e;
        int            t;
        N       = nmod;
        n_prime = np;
        start   = 1'b1;
        for (int k = 0; k < n; k++) begin
            a = rnd256() % nmod;
            b = rnd256() % nmod;
            p = {{MW{1'b0}}, a} * {{MW{1'b0}}, b};
            P = p;
            if (k > 0) begin
                t = 0;
                do begin
                    @(negedge clock);
                    t++;
                end while (!done && t < 30);
                if (!done) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_done_timeout item %0d", k);
                end
            end
            @(posedge clock);
            #1;
            e = '{model(p, nmod), 1'b1, 1'b0, cyc};
            sbq.push_back(e);
        end
        start = 1'b0;
        wait_drain();
    endtask

    logic [MW-1:0] n3;
    logic [MW-1:0] n25519;
    logic [63:0]   np3;
    logic [63:0]   np25519;
    logic [PW-1:0] pa;

    initial begin
        n3      = 256'd3;
        np3     = 64'h5555_5555_5555_5555;
        n25519  = (256'd1 << 255) - 256'd19;
        np25519 = np_of(n25519);

        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (R !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got R=%h busy=%b done=%b expected 0 0 0",
                     R, busy, done);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;

        issue('0, n3, np3, 256'd0, 1'b1, 1'b0);
        issue({256'd1, 256'd0}, n3, np3, 256'd1, 1'b1, 1'b0);
        issue({256'd3, 256'd0} - 512'd1, n3, np3, 256'd2, 1'b1, 1'b0);
        issue({256'd5, 256'd0}, n25519, np25519, 256'd5, 1'b1, 1'b0);

        run_stream(8, n25519, np25519);

        // abort: reset sampled on the fourth edge after acceptance
        pa      = {{MW{1'b0}}, rnd256() % n25519} * {{MW{1'b0}}, 256'd7};
        P       = pa;
        N       = n25519;
        n_prime = np25519;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (R !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got R=%h busy=%b done=%b expected 0 0 0",
                     R, busy, done);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        issue(pa, n25519, np25519, model(pa, n25519), 1'b1, 1'b0);

`ifdef MONT_REDC_CHECK_EN
        issue({256'd1, 256'd0}, 256'd4, 64'd0, '0, 1'b0, 1'b1);
        issue({256'd3, 256'd0}, n3, np3, '0, 1'b0, 1'b1);
        issue({256'd1, 256'd0}, n3, np3, 256'd1, 1'b1, 1'b0);
`endif

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
